tdm_demux2: RTL

TDM_DEMUX2 -- requirements
Module: tdm_demux2

---
 rtl/tdm_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/tdm_demux2.sv | 91 +++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and default widths for the 2:1 TDM demultiplexer.
package tdm_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ERR_W_DEF  = 8;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP0 = 2'd1,
        EXP1 = 2'd2
    } tdm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM receiver: aligns on s_sync, emits channel-0/1 word pairs
// and tracks framing violations.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] y,
    input  logic              y_valid,
    input  logic              s_sync,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic              frame_valid,
    output logic              lock,
    output logic              sync_err,
    output logic [ERR_W-1:0]  err_cnt
);

    tdm_state_e        state;
    logic [DATA_W-1:0] hold_p0;
    logic              err_event;

    // A violation is a sync beat where channel 1 was due, or a non-sync beat where channel 0 was due.
    always_comb begin
        err_event = 1'b0;
        if (y_valid) begin
            err_event = ((state == EXP1) && s_sync) || ((state == EXP0) && !s_sync);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            hold_p0     <= '0;
            w0          <= '0;
            w1          <= '0;
            frame_valid <= 1'b0;
            lock        <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= err_event;
            if (y_valid) begin
                case (state)
                    HUNT: begin
                        if (s_sync) begin
                            hold_p0 <= y;
                            state   <= EXP1;
                        end
                    end
                    EXP1: begin
                        if (!s_sync) begin
                            w0          <= hold_p0;
                            w1          <= y;
                            frame_valid <= 1'b1;
                            lock        <= 1'b1;
                            state       <= EXP0;
                        end else begin
                            // Resync on the newer channel-0 word rather than dropping to HUNT.
                            hold_p0 <= y;
                            lock    <= 1'b0;
                        end
                    end
                    EXP0: begin
                        if (s_sync) begin
                            hold_p0 <= y;
                            state   <= EXP1;
                        end else begin
                            lock  <= 1'b0;
                            state <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_event),
        .cnt  (err_cnt)
    );

endmodule
